div_iter: RTL
=============

Name: div_iter

Overview:
- Multi-cycle iterative divider in the execute stage; directly consumes the decoder's isdiv/signeddiv controls and the two register operands.
- Produces the quotient for LO and the remainder for HI, written by the HI/LO write path.
- Stalls the pipeline while busy.
- Radix-2 restoring division on magnitudes, with sign correction for signed DIV.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- div_start  in  1  isdiv of the instruction in E stage; held high while the instruction sits in E.
- signed_div  in  1  1 = DIV, 0 = DIVU; sampled with div_start.
- annul  in  1  flush/exception on the E-stage instruction; aborts the operation.
- opa  in  WIDTH  dividend (rs value).
- opb  in  WIDTH  divisor (rt value).
- stall_div  out  1  combinational; holds the pipeline while the divide is outstanding.
- ready  out  1  one-cycle pulse; quotient and remainder are valid and the HI/LO write fires this cycle.
- quotient  out  WIDTH  to LO.
- remainder  out  WIDTH  to HI.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE; counter = 0.
  - quotient = 0, remainder = 0, ready = 0.
  - stall_div is not forced; it follows the stall equation with state = IDLE.
  - Reset takes effect immediately, including mid-operation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If div_start & ~annul: latch |opa|, |opb| (absolute value only when signed_div), quotient sign = opa[W-1]^opb[W-1], remainder sign = opa[W-1] (signs forced 0 when unsigned).
  - Clear the partial remainder, counter = 0, go to BUSY.
- BUSY, one iteration per cycle:
  - Shift {rem, dividend} left 1.
  - If rem >= divisor: rem -= divisor and shift in 1; otherwise shift in 0.
  - counter increments; after 32 iterations (counter == WIDTH-1 on that cycle) go to DONE.
- DONE:
  - ready = 1 for exactly this cycle.
  - quotient/remainder registers take the sign-corrected results (two's-complement negate where the sign flag is set).
  - Next state is IDLE unconditionally; div_start is ignored in DONE.
- Latency:
  - Start sampled in IDLE at cycle T; BUSY during T+1..T+32; DONE/ready at T+33.
  - Results are available in the DONE cycle via a registered/bypassed result path.
  - Result registers hold their value until the next DONE.
- stall_div = (IDLE & div_start & ~annul) | BUSY; it is 0 in DONE, so the instruction leaves E on the DONE edge.
- Back-to-back DIVs: the second start is seen in IDLE the cycle after DONE. No extra bubble beyond that IDLE cycle.
- annul in IDLE or BUSY: next state IDLE, no ready pulse, result registers unchanged.
- annul in DONE: ready is still asserted; the downstream HI/LO write path gates it with the exception signal.
- Divide by zero: no trap and no early exit; the natural algorithm result is returned.
  - Magnitude: quotient all ones, remainder = |dividend|, then sign correction applies.
  - Signed 7/0 → quotient 0xFFFFFFFF, remainder 7.
  - Signed -7/0 → quotient 0x00000001, remainder 0xFFFFFFF9.
- Overflow 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0. No exception.
- Operand changes after the start cycle are ignored (operands are latched).
- Widths: internal remainder datapath is WIDTH+1 bits for the compare/subtract. The counter is clog2(WIDTH) bits and never wraps past WIDTH-1.

Decomposition:
- Shared defines header: state encodings DIV_IDLE/DIV_BUSY/DIV_DONE (2 bits) and the DIV_CYCLES constant (32).
- One natural sub-module: div_signfix, combinational.
  - Takes the magnitudes and the two sign flags; outputs the signed quotient and remainder.
  - Reused for operand absolute value via its negate path.
- The FSM, counter and shift datapath stay in div_iter.

Test Plan:
- Unsigned 100/7 with signed_div=0, start at T → stall_div high T..T+32, ready only at T+33, quotient=14, remainder=2; stall_div low at T+33.
- Signed -7 (0xFFFFFFF9) / 2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also unsigned 0xFFFFFFF9/2 → quotient=0x7FFFFFFC, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Then divide by zero 7/0 unsigned → quotient=0xFFFFFFFF, remainder=7, ready at T+33.
- annul asserted at BUSY cycle T+10 → state IDLE at T+11, no ready pulse ever, previous quotient/remainder unchanged. New start at T+12 with 9/3 → ready at T+45, quotient=3, remainder=0.
- Back-to-back: div_start held through DONE, second instruction's start seen in IDLE at T+34 → exactly one ready per instruction, at T+33 and T+67.
- resetn pulled low at T+20 asynchronously → quotient=0, remainder=0, ready=0 and state IDLE before the next edge. stall_div follows div_start after release.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and iteration count.
package div_iter_pkg;

    // Number of restoring-division iterations for a full-width operand
    localparam int unsigned DIV_CYCLES = 32;

    // Divider control states (2-bit encoding)
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_signfix.sv
// Conditional two's-complement negate of a quotient/remainder pair.
// Used both for operand absolute values and for final result sign correction.
module div_iter_signfix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_mag_q,
    input  logic [WIDTH-1:0] i_mag_r,
    input  logic             i_neg_q,
    input  logic             i_neg_r,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r
);

    // Negate each magnitude when its sign flag is set
    always_comb begin
        o_q = i_mag_q;
        o_r = i_mag_r;
        if (i_neg_q) begin
            o_q = WIDTH'(~i_mag_q + WIDTH'(1));
        end
        if (i_neg_r) begin
            o_r = WIDTH'(~i_mag_r + WIDTH'(1));
        end
    end

endmodule

// File: rtl/div_iter.sv
// Radix-2 restoring iterative divider for the execute stage.
// Quotient goes to LO, remainder to HI; stalls the pipeline while busy.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_CYCLES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned       CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       r_state;
    div_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;       // partial remainder
    logic [WIDTH-1:0] r_dvd;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_dvsr;      // latched divisor magnitude
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_ready;

    logic             w_start;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0] w_fix_r;

    assign w_start = div_start & ~annul;
    assign w_neg_a = signed_div & opa[WIDTH-1];
    assign w_neg_b = signed_div & opb[WIDTH-1];

    // Operand magnitudes through the shared negate path
    div_iter_signfix #(
        .WIDTH (WIDTH)
    ) u_abs (
        .i_mag_q (opa),
        .i_mag_r (opb),
        .i_neg_q (w_neg_a),
        .i_neg_r (w_neg_b),
        .o_q     (w_abs_a),
        .o_r     (w_abs_b)
    );

    // Sign correction of the finished magnitudes
    div_iter_signfix #(
        .WIDTH (WIDTH)
    ) u_fix (
        .i_mag_q (r_dvd),
        .i_mag_r (r_rem),
        .i_neg_q (r_neg_q),
        .i_neg_r (r_neg_r),
        .o_q     (w_fix_q),
        .o_r     (w_fix_r)
    );

    // One restoring step: shift in the next dividend bit, trial-subtract divisor
    always_comb begin
        w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
        w_rem_nxt = w_rem_sh[WIDTH-1:0];
        if (w_ge) begin
            w_rem_nxt = WIDTH'(w_rem_sh - {1'b0, r_dvsr});
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; annul aborts from IDLE or BUSY, DONE always returns to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (w_start) begin
                    w_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (annul) begin
                    w_next = DIV_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                w_next = DIV_IDLE;
            end
            default: begin
                w_next = DIV_IDLE;
            end
        endcase
    end

    // Ready pulse for the single DONE cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_next == DIV_DONE);
        end
    end

    // Operand latch, iteration counter and shift datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvsr  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_start) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_dvd   <= w_abs_a;
                        r_dvsr  <= w_abs_b;
                        r_neg_q <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_neg_r <= signed_div & opa[WIDTH-1];
                    end
                end
                DIV_BUSY: begin
                    if (!annul) begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                        if (r_cnt != CNT_LAST) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers capture the corrected values in DONE and hold until the next DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_quot <= '0;
            r_remd <= '0;
        end else if (r_state == DIV_DONE) begin
            r_quot <= w_fix_q;
            r_remd <= w_fix_r;
        end
    end

    // Results bypass the result registers during DONE so they are valid with ready
    assign quotient  = (r_state == DIV_DONE) ? w_fix_q : r_quot;
    assign remainder = (r_state == DIV_DONE) ? w_fix_r : r_remd;
    assign ready     = r_ready;
    assign stall_div = ((r_state == DIV_IDLE) & w_start) | (r_state == DIV_BUSY);

endmodule
